// File: rtl/mem_pkg.sv
// Memory-map constants and shared types for the CPU memory interface.
// Holds the sprite DMA trigger/destination addresses and the DMA FSM state type.
package mem_pkg;

    // CPU write to this address starts a sprite DMA; write data is the source page
    localparam logic [15:0] ADDR_SPR_RAM_DMA = 16'h4014;
    // OAM data port; every DMA byte is written here
    localparam logic [15:0] ADDR_OAM_DATA    = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        RD,
        WR
    } spr_dma_state_t;

endpackage

// File: rtl/spr_dma_master.sv
// Sprite-RAM DMA engine. Snoops CPU writes to TRIG_ADDR, stalls the CPU and
// copies XFER_LEN bytes from page {data,00} to OAM_ADDR, one read/write pair per byte.
// Optional feature: define SPR_DMA_ALIGN_EN to insert one ALIGN cycle after HALT
// when the CPU cycle parity is odd; otherwise ALIGN is unreachable.
module spr_dma_master
    import mem_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = ADDR_SPR_RAM_DMA,
    parameter logic [15:0] OAM_ADDR  = ADDR_OAM_DATA,
    parameter int          XFER_LEN  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wen,
    output logic        cpu_rdy,
    output logic        dma_own,
    output logic [15:0] dma_addr_out,
    output logic        dma_ren,
    output logic        dma_wen,
    output logic [7:0]  dma_data_out,
    input  logic [7:0]  dma_data_in,
    output logic        busy
);

    // idx counts 0..XFER_LEN-1; the last WR happens with idx at this value
    localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

    spr_dma_state_t state, state_nxt;
    logic [7:0] page;
    logic [8:0] idx;
    logic       parity;
    logic [7:0] rd_buf;
    logic       trig;

    assign trig = cpu_wen && (cpu_addr == TRIG_ADDR);
    assign busy = ~cpu_rdy;

`ifndef SPR_DMA_ALIGN_EN
    // parity only steers the ALIGN decision; keep it referenced when that is compiled out
    logic unused_parity;
    assign unused_parity = parity;
`endif

    // Next-state and Moore output decode from the registered state
    always_comb begin
        state_nxt    = state;
        cpu_rdy      = 1'b1;
        dma_own      = 1'b0;
        dma_ren      = 1'b0;
        dma_wen      = 1'b0;
        dma_addr_out = 16'h0000;
        dma_data_out = 8'h00;
        case (state)
            IDLE: begin
                if (trig) state_nxt = HALT;
            end
            HALT: begin
                cpu_rdy = 1'b0;
                dma_own = 1'b1;
`ifdef SPR_DMA_ALIGN_EN
                state_nxt = parity ? ALIGN : RD;
`else
                state_nxt = RD;
`endif
            end
            ALIGN: begin
                cpu_rdy   = 1'b0;
                dma_own   = 1'b1;
                state_nxt = RD;
            end
            RD: begin
                cpu_rdy      = 1'b0;
                dma_own      = 1'b1;
                dma_ren      = 1'b1;
                // page byte is fixed; idx[7:0] wraps without carrying into it
                dma_addr_out = {page, idx[7:0]};
                state_nxt    = WR;
            end
            WR: begin
                cpu_rdy      = 1'b0;
                dma_own      = 1'b1;
                dma_wen      = 1'b1;
                dma_addr_out = OAM_ADDR;
                dma_data_out = rd_buf;
                state_nxt    = (idx == LAST_IDX) ? IDLE : RD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, page latch, byte index, read buffer and CPU cycle parity
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 9'd0;
            parity <= 1'b0;
            rd_buf <= 8'h00;
        end else begin
            parity <= ~parity;
            state  <= state_nxt;
            case (state)
                IDLE: if (trig) begin
                    page <= cpu_data;
                    idx  <= 9'd0;
                end
                RD:      rd_buf <= dma_data_in;
                WR:      idx    <= idx + 9'd1;
                default: ;
            endcase
        end
    end

endmodule
